// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    localparam int          MULDIV_ITERS = 32;
    localparam logic [31:0] DIV0_QUO     = '1;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_div(muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic a_is_signed(muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_is_signed(muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// Request/response bundle between the EX stage (master) and the mul/div sequencer (slave).
interface ex_muldiv_seq_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/adder_33_bit.sv
// 33-bit combinational adder; zero latency, no flow control.
module adder_33_bit (
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [32:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration on unsigned magnitudes.
// Purely combinational; the caller registers acc/mq each cycle.
module muldiv_step (
    input  logic        is_div,
    input  logic [32:0] acc,
    input  logic [31:0] mq,
    input  logic [31:0] operand,
    output logic [32:0] acc_nxt,
    output logic [31:0] mq_nxt
);
    logic [32:0] add_sum;
    logic [32:0] sub_diff;
    logic [32:0] shifted;
    logic [32:0] partial;

    // Divide shifts the next dividend bit (quo msb) into the partial remainder.
    assign shifted = {acc[31:0], mq[31]};

    adder_33_bit u_add (
        .a   (acc),
        .b   ({1'b0, operand}),
        .sum (add_sum)
    );

    substractor_33_bit u_sub (
        .a    (shifted),
        .b    ({1'b0, operand}),
        .diff (sub_diff)
    );

    always_comb begin
        acc_nxt = acc;
        mq_nxt  = mq;
        partial = mq[0] ? add_sum : acc;
        if (is_div) begin
            if (!sub_diff[32]) begin
                acc_nxt = sub_diff;
                mq_nxt  = {mq[30:0], 1'b1};
            end else begin
                acc_nxt = shifted;
                mq_nxt  = {mq[30:0], 1'b0};
            end
        end else begin
            acc_nxt = {1'b0, partial[32:1]};
            mq_nxt  = {partial[0], mq[31:1]};
        end
    end
endmodule

// File: rtl/substractor_33_bit.sv
// 33-bit combinational subtractor; bit 32 of diff is the borrow. Zero latency.
module substractor_33_bit (
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [32:0] diff
);
    assign diff = a - b;
endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M MUL/DIV sequencer: 34 cycles accept-to-result (1 for divide by zero), 1 op per 35 cycles.
// Holds the result in DONE until out_ready; in_ready only in IDLE, flush aborts from any state.
module ex_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    ex_muldiv_seq_if.slave       bus,
    output logic                 busy
);
    muldiv_state_e      state_q, state_d;
    muldiv_op_e         op_q, in_op;
    logic [4:0]         cnt_q;
    logic [TAG_W-1:0]   tag_q;
    logic               neg_q;
    logic [XLEN:0]      acc_q, step_acc;
    logic [XLEN-1:0]    mq_q, opnd_q, res_q, step_mq;
    logic [XLEN-1:0]    mag_a, mag_b, fix_res;
    logic [2*XLEN-1:0]  prod, prod_neg;
    logic               accept, op_div, div0, a_neg, b_neg, neg_in;

    assign in_op  = muldiv_op_e'(bus.in_op);
    assign op_div = is_div(in_op);
    assign a_neg  = a_is_signed(in_op) && bus.in_a[XLEN-1];
    assign b_neg  = b_is_signed(in_op) && bus.in_b[XLEN-1];
    // Magnitude of -2^31 wraps back to 0x80000000, which is correct as unsigned.
    assign mag_a  = a_neg ? -bus.in_a : bus.in_a;
    assign mag_b  = b_neg ? -bus.in_b : bus.in_b;
    assign neg_in = a_neg ^ (is_rem(in_op) ? 1'b0 : b_neg);
    assign div0   = op_div && (bus.in_b == '0);
    assign accept = (state_q == IDLE) && bus.in_valid && !flush;

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;
    assign bus.out_tag    = tag_q;
    assign busy           = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = div0 ? DONE : CALC;
            CALC: if (cnt_q == 5'(MULDIV_ITERS - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    muldiv_step u_step (
        .is_div  (is_div(op_q)),
        .acc     (acc_q),
        .mq      (mq_q),
        .operand (opnd_q),
        .acc_nxt (step_acc),
        .mq_nxt  (step_mq)
    );

    assign prod     = {acc_q[XLEN-1:0], mq_q};
    assign prod_neg = -prod;

    always_comb begin
        fix_res = '0;
        case (op_q)
            OP_MUL:                       fix_res = neg_q ? prod_neg[XLEN-1:0] : prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = neg_q ? prod_neg[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = neg_q ? -mq_q : mq_q;
            default:                      fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        endcase
    end

    // Multiply: mq holds the multiplier, opnd the multiplicand.
    // Divide: mq holds the dividend shifting into the quotient, opnd the divisor.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= OP_MUL;
            tag_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            mq_q   <= '0;
            opnd_q <= '0;
            res_q  <= '0;
        end else if (accept) begin
            op_q   <= in_op;
            tag_q  <= bus.in_tag;
            neg_q  <= neg_in;
            cnt_q  <= '0;
            acc_q  <= '0;
            mq_q   <= op_div ? mag_a : mag_b;
            opnd_q <= op_div ? mag_b : mag_a;
            if (div0) res_q <= is_rem(in_op) ? bus.in_a : DIV0_QUO;
        end else if (state_q == CALC) begin
            acc_q <= step_acc;
            mq_q  <= step_mq;
            cnt_q <= cnt_q + 5'd1;
        end else if (state_q == FIX) begin
            res_q <= fix_res;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Randomised scoreboard bench for ex_muldiv_seq against an arithmetic reference model.
module tb_ex_muldiv_seq;
    logic clock, reset, flush, busy;

    ex_muldiv_seq_if bus ();

    ex_muldiv_seq dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave),
        .busy  (busy)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rmode = 0;
    bit   prev_valid = 0;
    bit   chk_idle = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb_, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        case (op)
            0: begin p = sa * sb_; return p[31:0];  end
            1: begin p = sa * sb_; return p[63:32]; end
            2: begin p = sa * ub;  return p[63:32]; end
            3: begin p = ua * ub;  return p[63:32]; end
            4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb_; return p[31:0]; end
            5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            6: begin if (b == 0) return a; p = sa % sb_; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // out_ready driver: random, forced low, or forced high.
    initial begin
        bus.out_ready = 0;
        forever begin
            @(posedge clock);
            #1;
            case (rmode)
                1: bus.out_ready = 0;
                2: bus.out_ready = 1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            if (chk_idle) begin
                chk("idle_after_pop", bus.in_ready, 1);
                chk("not_busy_after_pop", busy, 0);
                chk_idle = 0;
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%0h required=none", bus.out_result);
                end else begin
                    if (!prev_valid) chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
                    chk("result", bus.out_result, sb[0].res);
                    chk("tag", bus.out_tag, sb[0].tag);
                    chk("in_ready_in_done", bus.in_ready, 0);
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        chk_idle = 1;
                    end
                end
            end
            prev_valid = bus.out_valid;
        end
    end

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] res, input bit keep);
        exp_t e;
        bit   got = 0;
        @(posedge clock);
        #1;
        bus.in_valid = 1;
        bus.in_op    = op[2:0];
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clock);
            if (bus.in_ready) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_in_ready required=in_ready");
        end else if (keep) begin
            e.res     = res;
            e.tag     = tag;
            e.acc_cyc = cyc;
            e.lat     = (op >= 4 && b == 0) ? 1 : 34;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 0;
        bus.in_op    = 3'($urandom());
        bus.in_a     = $urandom();
        bus.in_b     = $urandom();
        bus.in_tag   = 5'($urandom());
    endtask

    // Accept an op, then kill it with flush or reset n cycles into CALC.
    task automatic abort(input int n, input bit use_reset);
        issue($urandom_range(0, 7), rand_val(), rand_val() | 32'h1, 5'($urandom()), 32'h0, 0);
        repeat (n) @(posedge clock);
        #1;
        if (use_reset) reset = 1;
        else           flush = 1;
        @(posedge clock);
        #1;
        reset = 0;
        flush = 0;
        @(negedge clock);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        if (use_reset) begin
            chk("abort_rst_result", bus.out_result, 0);
            chk("abort_rst_tag", bus.out_tag, 0);
        end
    endtask

    int          d_op  [10] = '{0, 1, 3, 2, 4, 6, 4, 6, 5, 7};
    logic [31:0] d_a   [10] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
    logic [31:0] d_b   [10] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                                32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] d_res [10] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'd5};

    initial begin
        int          op;
        logic [31:0] a, b;
        reset        = 1;
        flush        = 0;
        bus.in_valid = 0;
        bus.in_op    = 0;
        bus.in_a     = 0;
        bus.in_b     = 0;
        bus.in_tag   = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_result", bus.out_result, 0);
        chk("rst_tag", bus.out_tag, 0);
        @(posedge clock);
        #1;
        reset = 0;

        for (int i = 0; i < 10; i++)
            issue(d_op[i], d_a[i], d_b[i], 5'(i + 3), d_res[i], 1);

        // Result must sit unchanged in DONE while the consumer stalls.
        rmode = 1;
        issue(4, 32'd100, 32'd7, 5'h1A, 32'd14, 1);
        for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clock);
        chk("hold_wait_valid", bus.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        rmode = 2;
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
        chk("hold_drained", sb.size(), 0);
        rmode = 0;

        // flush beats a simultaneous request in IDLE.
        @(posedge clock);
        #1;
        bus.in_valid = 1;
        bus.in_op    = 3'd0;
        flush        = 1;
        @(negedge clock);
        chk("flush_in_ready", bus.in_ready, 1);
        @(posedge clock);
        #1;
        bus.in_valid = 0;
        flush        = 0;
        @(negedge clock);
        chk("flush_no_accept", busy, 0);

        abort(15, 0);
        issue(0, 32'd12345, 32'd678, 5'h11, ref_model(0, 32'd12345, 32'd678), 1);
        abort(20, 1);
        issue(6, 32'hFFFF_FF00, 32'd7, 5'h12, ref_model(6, 32'hFFFF_FF00, 32'd7), 1);

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clock);
            if ($urandom_range(0, 7) == 0) begin
                abort($urandom_range(0, 32), 1'($urandom_range(0, 1)));
            end else begin
                op = $urandom_range(0, 7);
                a  = rand_val();
                b  = rand_val();
                issue(op, a, b, 5'($urandom()), ref_model(op, a, b), 1);
            end
        end

        for (int i = 0; i < 2000 && sb.size() > 0; i++) @(negedge clock);
        chk("final_drained", sb.size(), 0);
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
